// File: rtl/line_drawer.sv
// Bresenham line engine: latches two endpoints and a colour on a start pulse,
// then emits one pixel write per clock and a one-cycle done pulse.
module line_drawer (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [8:0] i_x0,
   input  logic [7:0] i_y0,
   input  logic [8:0] i_x1,
   input  logic [7:0] i_y1,
   input  logic [2:0] i_col,
   output logic [8:0] o_x,
   output logic [7:0] o_y,
   output logic [2:0] o_col,
   output logic       o_plot,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;

   state_t     state, state_nx;
   logic [8:0] lx0, lx1, lx0_nx, lx1_nx;
   logic [7:0] ly0, ly1, ly0_nx, ly1_nx;
   logic [2:0] lcol, lcol_nx;
   logic [8:0] x, y, x_end, dx, dy;
   logic [8:0] x_nx, y_nx, x_end_nx, dx_nx, dy_nx;
   logic [10:0] err, err_nx;
   logic       steep, steep_nx, yneg, yneg_nx;
   logic [8:0] ox_nx;
   logic [7:0] oy_nx;
   logic [2:0] ocol_nx;
   logic       plot_nx, busy_nx, done_nx;

   // Setup math: Y is widened to 9 bits so a steep swap can put it in the x role
   logic [8:0] ey0, ey1, adx, ady, sx0, sy0, sx1, sy1, fx0, fy0, fx1, fy1;
   logic       init_steep, init_swap;
   assign ey0        = {1'b0, ly0};
   assign ey1        = {1'b0, ly1};
   assign adx        = (lx1 >= lx0) ? (lx1 - lx0) : (lx0 - lx1);
   assign ady        = (ey1 >= ey0) ? (ey1 - ey0) : (ey0 - ey1);
   assign init_steep = (ady > adx);
   assign sx0        = init_steep ? ey0 : lx0;
   assign sy0        = init_steep ? lx0 : ey0;
   assign sx1        = init_steep ? ey1 : lx1;
   assign sy1        = init_steep ? lx1 : ey1;
   assign init_swap  = (sx0 > sx1);
   assign fx0        = init_swap ? sx1 : sx0;
   assign fy0        = init_swap ? sy1 : sy0;
   assign fx1        = init_swap ? sx0 : sx1;
   assign fy1        = init_swap ? sy0 : sy1;

   // Per-pixel error step
   logic [10:0] err_p;
   logic        step_y, last;
   logic [8:0]  y_step, x_inc;
   assign err_p  = err + {2'b00, dy};
   assign step_y = ($signed(err_p) > 11'sd0);
   assign y_step = yneg ? (y - 9'd1) : (y + 9'd1);
   assign x_inc  = x + 9'd1;
   assign last   = (x == x_end);

   // State register and all datapath/output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         lx0   <= 9'd0;  ly0 <= 8'd0;  lx1 <= 9'd0;  ly1 <= 8'd0;  lcol <= 3'd0;
         x     <= 9'd0;  y   <= 9'd0;  x_end <= 9'd0;
         dx    <= 9'd0;  dy  <= 9'd0;  err <= 11'd0;
         steep <= 1'b0;  yneg <= 1'b0;
         o_x   <= 9'd0;  o_y <= 8'd0;  o_col <= 3'd0;
         o_plot <= 1'b0; o_busy <= 1'b0; o_done <= 1'b0;
      end else begin
         state <= state_nx;
         lx0   <= lx0_nx;  ly0 <= ly0_nx;  lx1 <= lx1_nx;  ly1 <= ly1_nx;  lcol <= lcol_nx;
         x     <= x_nx;    y   <= y_nx;    x_end <= x_end_nx;
         dx    <= dx_nx;   dy  <= dy_nx;   err <= err_nx;
         steep <= steep_nx; yneg <= yneg_nx;
         o_x   <= ox_nx;   o_y <= oy_nx;   o_col <= ocol_nx;
         o_plot <= plot_nx; o_busy <= busy_nx; o_done <= done_nx;
      end
   end

   // Next-state and next-register logic; outputs are registered one step ahead
   always_comb begin
      state_nx = state;
      lx0_nx = lx0;  ly0_nx = ly0;  lx1_nx = lx1;  ly1_nx = ly1;  lcol_nx = lcol;
      x_nx = x;  y_nx = y;  x_end_nx = x_end;
      dx_nx = dx;  dy_nx = dy;  err_nx = err;
      steep_nx = steep;  yneg_nx = yneg;
      ox_nx = o_x;  oy_nx = o_y;  ocol_nx = o_col;
      plot_nx = 1'b0;  busy_nx = 1'b0;  done_nx = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               lx0_nx = i_x0;  ly0_nx = i_y0;  lx1_nx = i_x1;  ly1_nx = i_y1;
               lcol_nx = i_col;
               busy_nx = 1'b1;
               state_nx = INIT;
            end else begin
               state_nx = IDLE;
            end
         end
         INIT: begin
            x_nx     = fx0;
            y_nx     = fy0;
            x_end_nx = fx1;
            dx_nx    = fx1 - fx0;
            dy_nx    = (fy1 >= fy0) ? (fy1 - fy0) : (fy0 - fy1);
            yneg_nx  = !(fy0 < fy1);
            err_nx   = 11'd0 - {3'b000, dx_nx[8:1]};
            steep_nx = init_steep;
            ox_nx    = init_steep ? fy0 : fx0;
            oy_nx    = init_steep ? fx0[7:0] : fy0[7:0];
            ocol_nx  = lcol;
            plot_nx  = 1'b1;
            busy_nx  = 1'b1;
            state_nx = DRAW;
         end
         DRAW: begin
            err_nx = step_y ? (err_p - {2'b00, dx}) : err_p;
            y_nx   = step_y ? y_step : y;
            if (last) begin
               done_nx  = 1'b1;
               state_nx = DONE;
            end else begin
               x_nx    = x_inc;
               ox_nx   = steep ? y_nx : x_inc;
               oy_nx   = steep ? x_inc[7:0] : y_nx[7:0];
               plot_nx = 1'b1;
               busy_nx = 1'b1;
               state_nx = DRAW;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_line_drawer.sv
// Directed self-checking bench for line_drawer: each line's pixel sequence
// is hand-derived and compared cycle by cycle on the falling edge.
module tb_line_drawer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_start = 1'b0;
   logic [8:0] i_x0 = 9'd0;
   logic [7:0] i_y0 = 8'd0;
   logic [8:0] i_x1 = 9'd0;
   logic [7:0] i_y1 = 8'd0;
   logic [2:0] i_col = 3'd0;
   logic [8:0] o_x;
   logic [7:0] o_y;
   logic [2:0] o_col;
   logic       o_plot, o_busy, o_done;

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];

   line_drawer dut (
      .clk(clk), .reset(reset), .i_start(i_start),
      .i_x0(i_x0), .i_y0(i_y0), .i_x1(i_x1), .i_y1(i_y1), .i_col(i_col),
      .o_x(o_x), .o_y(o_y), .o_col(o_col),
      .o_plot(o_plot), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic px(input int xv, input int yv);
      exp_q.push_back({9'(xv), 8'(yv)});
   endtask

   // Start a line, check every expected pixel, then the done pulse.
   // glitch >= 0 pulses i_start with different inputs during that pixel.
   task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                           input int col, input int glitch);
      @(negedge clk);
      i_x0 = 9'(x0); i_y0 = 8'(y0); i_x1 = 9'(x1); i_y1 = 8'(y1); i_col = 3'(col);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("init_plot", 32'(o_plot), 32'd0);
      chk("init_busy", 32'(o_busy), 32'd1);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         i_start = 1'b0;
         chk($sformatf("plot[%0d]", i), 32'(o_plot), 32'd1);
         chk($sformatf("x[%0d]", i), 32'(o_x), 32'(exp_q[i][16:8]));
         chk($sformatf("y[%0d]", i), 32'(o_y), 32'(exp_q[i][7:0]));
         chk($sformatf("col[%0d]", i), 32'(o_col), 32'(col));
         chk($sformatf("done_early[%0d]", i), 32'(o_done), 32'd0);
         if (i == glitch) begin
            i_start = 1'b1;
            i_x0 = 9'd100; i_y0 = 8'd50; i_x1 = 9'd200; i_y1 = 8'd150; i_col = 3'd1;
         end
      end
      @(negedge clk);
      i_start = 1'b0;
      chk("done_pulse", 32'(o_done), 32'd1);
      chk("done_plot", 32'(o_plot), 32'd0);
      chk("done_busy", 32'(o_busy), 32'd0);
      @(negedge clk);
      chk("after_done", 32'(o_done), 32'd0);
      chk("after_plot", 32'(o_plot), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_x", 32'(o_x), 32'd0);
      chk("rst_y", 32'(o_y), 32'd0);
      chk("rst_col", 32'(o_col), 32'd0);
      chk("rst_plot", 32'(o_plot), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // 1. Horizontal
      for (int i = 0; i <= 4; i++) px(i, 0);
      run_line(0, 0, 4, 0, 5, -1);

      // 2. Steep
      px(10, 10); px(10, 11); px(11, 12); px(11, 13); px(12, 14); px(12, 15);
      run_line(10, 10, 12, 15, 3, -1);

      // 3. Reversed endpoints and negative y step
      px(0, 0); px(1, 1); px(2, 1); px(3, 2); px(4, 3);
      run_line(4, 3, 0, 0, 2, -1);
      px(0, 3); px(1, 2); px(2, 2); px(3, 1); px(4, 0);
      run_line(0, 3, 4, 0, 6, -1);

      // 4. Single point at the screen corner
      px(319, 239);
      run_line(319, 239, 319, 239, 7, -1);

      // 5. Start pulse while busy is ignored
      for (int i = 0; i <= 9; i++) px(i, 0);
      run_line(0, 0, 9, 0, 4, 3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_second_plot", 32'(o_plot), 32'd0);
         chk("no_second_busy", 32'(o_busy), 32'd0);
      end

      // 6. Reset during the third pixel of a diagonal
      @(negedge clk);
      i_x0 = 9'd0; i_y0 = 8'd0; i_x1 = 9'd9; i_y1 = 8'd9; i_col = 3'd5;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("mid_plot", 32'(o_plot), 32'd1);
      chk("mid_x", 32'(o_x), 32'd2);
      chk("mid_y", 32'(o_y), 32'd2);
      #1 reset = 1'b1;
      #1;
      chk("arst_plot", 32'(o_plot), 32'd0);
      chk("arst_x", 32'(o_x), 32'd0);
      chk("arst_y", 32'(o_y), 32'd0);
      chk("arst_col", 32'(o_col), 32'd0);
      chk("arst_busy", 32'(o_busy), 32'd0);
      chk("arst_done", 32'(o_done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(o_done), 32'd0);
         chk("post_rst_plot", 32'(o_plot), 32'd0);
      end
      px(1, 1); px(2, 2);
      run_line(1, 1, 2, 2, 3, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
